// File: rtl/mimo_zf_2x2_if.sv
// Sample/coefficient bundle for the 2x2 zero-forcing equalizer.
// The master drives Y/H_inv with in_valid. The slave returns X with out_valid.
interface mimo_zf_2x2_if #(
  parameter int DATA_W = 16
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] Y1_re, Y1_im, Y2_re, Y2_im;
  logic signed [DATA_W-1:0] h00_re, h00_im, h01_re, h01_im;
  logic signed [DATA_W-1:0] h10_re, h10_im, h11_re, h11_im;
  logic                     out_valid;
  logic signed [DATA_W-1:0] X1_re, X1_im, X2_re, X2_im;

  modport master (
    output in_valid, Y1_re, Y1_im, Y2_re, Y2_im,
           h00_re, h00_im, h01_re, h01_im, h10_re, h10_im, h11_re, h11_im,
    input  out_valid, X1_re, X1_im, X2_re, X2_im
  );

  modport slave (
    input  in_valid, Y1_re, Y1_im, Y2_re, Y2_im,
           h00_re, h00_im, h01_re, h01_im, h10_re, h10_im, h11_re, h11_im,
    output out_valid, X1_re, X1_im, X2_re, X2_im
  );
endinterface

// File: rtl/mimo_zf_2x2.sv
// 2x2 zero-forcing equalizer: X = H_inv * Y, using a 3-stage feed-forward pipeline.
// Stage 1 registers the inputs, stage 2 forms 16 real products, and stage 3 sums, rounds and saturates.
module mimo_zf_2x2 #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 14
) (
  input  logic         clk,
  input  logic         rst,
  mimo_zf_2x2_if.slave bus
);
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = 2 * DATA_W + 2;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((longint'(1) <<< (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - 1;
  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(longint'(1) <<< (FRAC_W - 1));

  typedef logic signed [DATA_W-1:0] smp_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  smp_t  y_re_in [2], y_im_in [2];
  smp_t  h_re_in [2][2], h_im_in [2][2];
  smp_t  y_re_q  [2], y_im_q  [2];
  smp_t  h_re_q  [2][2], h_im_q  [2][2];
  prod_t p_rr_q  [2][2], p_ii_q  [2][2], p_ri_q [2][2], p_ir_q [2][2];
  logic signed [ACC_W-1:0] acc_re [2], acc_im [2];
  smp_t  x_re_q  [2], x_im_q  [2];
  logic [2:0] vld_q;

  assign y_re_in[0] = bus.Y1_re;   assign y_im_in[0] = bus.Y1_im;
  assign y_re_in[1] = bus.Y2_re;   assign y_im_in[1] = bus.Y2_im;
  assign h_re_in[0][0] = bus.h00_re; assign h_im_in[0][0] = bus.h00_im;
  assign h_re_in[0][1] = bus.h01_re; assign h_im_in[0][1] = bus.h01_im;
  assign h_re_in[1][0] = bus.h10_re; assign h_im_in[1][0] = bus.h10_im;
  assign h_re_in[1][1] = bus.h11_re; assign h_im_in[1][1] = bus.h11_im;

  // Round half toward +inf, then clamp into the output range.
  function automatic smp_t round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] r;
    r = (acc + RND) >>> FRAC_W;
    if (r > SAT_MAX)      round_sat = SAT_MAX[DATA_W-1:0];
    else if (r < SAT_MIN) round_sat = SAT_MIN[DATA_W-1:0];
    else                  round_sat = r[DATA_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= {vld_q[1:0], bus.in_valid};
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_row
    always_ff @(posedge clk) begin
      if (rst) begin
        y_re_q[gi] <= '0;
        y_im_q[gi] <= '0;
      end else if (bus.in_valid) begin
        y_re_q[gi] <= y_re_in[gi];
        y_im_q[gi] <= y_im_in[gi];
      end
    end

    for (genvar gj = 0; gj < 2; gj++) begin : g_col
      always_ff @(posedge clk) begin
        if (rst) begin
          h_re_q[gi][gj] <= '0;
          h_im_q[gi][gj] <= '0;
        end else if (bus.in_valid) begin
          h_re_q[gi][gj] <= h_re_in[gi][gj];
          h_im_q[gi][gj] <= h_im_in[gi][gj];
        end
      end

      // Row gi of H_inv times element gj of Y: four real partial products.
      always_ff @(posedge clk) begin
        if (rst) begin
          p_rr_q[gi][gj] <= '0;
          p_ii_q[gi][gj] <= '0;
          p_ri_q[gi][gj] <= '0;
          p_ir_q[gi][gj] <= '0;
        end else if (vld_q[0]) begin
          p_rr_q[gi][gj] <= prod_t'(h_re_q[gi][gj]) * prod_t'(y_re_q[gj]);
          p_ii_q[gi][gj] <= prod_t'(h_im_q[gi][gj]) * prod_t'(y_im_q[gj]);
          p_ri_q[gi][gj] <= prod_t'(h_re_q[gi][gj]) * prod_t'(y_im_q[gj]);
          p_ir_q[gi][gj] <= prod_t'(h_im_q[gi][gj]) * prod_t'(y_re_q[gj]);
        end
      end
    end

    assign acc_re[gi] = ACC_W'(p_rr_q[gi][0]) - ACC_W'(p_ii_q[gi][0])
                      + ACC_W'(p_rr_q[gi][1]) - ACC_W'(p_ii_q[gi][1]);
    assign acc_im[gi] = ACC_W'(p_ri_q[gi][0]) + ACC_W'(p_ir_q[gi][0])
                      + ACC_W'(p_ri_q[gi][1]) + ACC_W'(p_ir_q[gi][1]);

    always_ff @(posedge clk) begin
      if (rst) begin
        x_re_q[gi] <= '0;
        x_im_q[gi] <= '0;
      end else if (vld_q[1]) begin
        x_re_q[gi] <= round_sat(acc_re[gi]);
        x_im_q[gi] <= round_sat(acc_im[gi]);
      end
    end
  end

  assign bus.out_valid = vld_q[2];
  assign bus.X1_re = x_re_q[0];
  assign bus.X1_im = x_im_q[0];
  assign bus.X2_re = x_re_q[1];
  assign bus.X2_im = x_im_q[1];
endmodule

// File: tb/tb_mimo_zf_2x2.sv
// Scoreboard bench for mimo_zf_2x2.
// The driver queues the expected X plus the issue cycle, and a negedge monitor pops and compares them.
module tb_mimo_zf_2x2;
  localparam int DW = 16;
  localparam int FW = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mimo_zf_2x2_if #(.DATA_W(DW)) bus ();
  mimo_zf_2x2 #(.DATA_W(DW), .FRAC_W(FW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed { int x1r; int x1i; int x2r; int x2i; int cyc; } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hr[8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: exact integer sum, floor((acc + half) / 2^FW), then clamp.
  function automatic int rsat(input longint acc);
    longint r, mx, mn;
    mx = (longint'(1) <<< (DW - 1)) - 1;
    mn = -mx - 1;
    r = (acc + (longint'(1) <<< (FW - 1))) >>> FW;
    if (r > mx) return int'(mx);
    if (r < mn) return int'(mn);
    return int'(r);
  endfunction

  task automatic send(input bit vld,
                      input int h00r, input int h00i, input int h01r, input int h01i,
                      input int h10r, input int h10i, input int h11r, input int h11i,
                      input int y1r, input int y1i, input int y2r, input int y2i,
                      input bit hand, input int e1r, input int e1i, input int e2r, input int e2i);
    exp_t e;
    bus.in_valid = vld;
    bus.h00_re = DW'(h00r); bus.h00_im = DW'(h00i);
    bus.h01_re = DW'(h01r); bus.h01_im = DW'(h01i);
    bus.h10_re = DW'(h10r); bus.h10_im = DW'(h10i);
    bus.h11_re = DW'(h11r); bus.h11_im = DW'(h11i);
    bus.Y1_re  = DW'(y1r);  bus.Y1_im  = DW'(y1i);
    bus.Y2_re  = DW'(y2r);  bus.Y2_im  = DW'(y2i);
    if (vld) begin
      if (hand) begin
        e = '{e1r, e1i, e2r, e2i, cyc};
      end else begin
        e.x1r = rsat(longint'(h00r)*y1r - longint'(h00i)*y1i + longint'(h01r)*y2r - longint'(h01i)*y2i);
        e.x1i = rsat(longint'(h00r)*y1i + longint'(h00i)*y1r + longint'(h01r)*y2i + longint'(h01i)*y2r);
        e.x2r = rsat(longint'(h10r)*y1r - longint'(h10i)*y1i + longint'(h11r)*y2r - longint'(h11i)*y2i);
        e.x2i = rsat(longint'(h10r)*y1i + longint'(h10i)*y1r + longint'(h11r)*y2i + longint'(h11i)*y2r);
        e.cyc = cyc;
      end
      sb_q.push_back(e);
      $display("IN  cyc=%0d Y1=(%0d,%0d) Y2=(%0d,%0d) exp X1=(%0d,%0d) X2=(%0d,%0d)",
               cyc, y1r, y1i, y2r, y2i, e.x1r, e.x1i, e.x2r, e.x2i);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stale_out_valid actual=1 required=0 cyc=%0d", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        $display("OUT cyc=%0d X1=(%0d,%0d) X2=(%0d,%0d)", cyc,
                 int'(bus.X1_re), int'(bus.X1_im), int'(bus.X2_re), int'(bus.X2_im));
        chk("latency", cyc - mon_e.cyc, 3);
        chk("X1_re", int'(bus.X1_re), mon_e.x1r);
        chk("X1_im", int'(bus.X1_im), mon_e.x1i);
        chk("X2_re", int'(bus.X2_re), mon_e.x2r);
        chk("X2_im", int'(bus.X2_im), mon_e.x2i);
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.h00_re = '0; bus.h00_im = '0; bus.h01_re = '0; bus.h01_im = '0;
    bus.h10_re = '0; bus.h10_im = '0; bus.h11_re = '0; bus.h11_im = '0;
    bus.Y1_re = '0; bus.Y1_im = '0; bus.Y2_re = '0; bus.Y2_im = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_X1_re", int'(bus.X1_re), 0);
    chk("rst_X1_im", int'(bus.X1_im), 0);
    chk("rst_X2_re", int'(bus.X2_re), 0);
    chk("rst_X2_im", int'(bus.X2_im), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Identity, swap/complex, rounding, saturation, complex coefficient
    send(1, 16384,0, 0,0, 0,0, 16384,0, 1000,-2000, 300,400, 1, 1000,-2000, 300,400);
    send(1, 0,0, 0,16384, 16384,0, 0,0, 100,50, -70,20, 1, -20,-70, 100,50);
    send(1, 8192,0, 0,0, 0,0, 0,0, 3,0, 0,0, 1, 2,0, 0,0);
    send(1, 8192,0, 0,0, 0,0, 0,0, -3,0, 0,0, 1, -1,0, 0,0);
    send(1, 16384,0, 16384,0, 0,0, 0,0, 30000,0, 30000,0, 1, 32767,0, 0,0);
    send(1, 16384,0, 16384,0, 0,0, 0,0, -30000,0, -30000,0, 1, -32768,0, 0,0);
    send(1, 8192,8192, 0,0, 0,0, 0,0, 100,200, 0,0, 1, -50,150, 0,0);
    idle(4);

    // Bubble pattern 1,0,1,1
    send(1, 16384,0, 0,0, 0,0, 16384,0, 11,-12, 13,-14, 1, 11,-12, 13,-14);
    send(0, 0,0, 0,0, 0,0, 0,0, 999,999, 999,999, 1, 0,0, 0,0);
    send(1, 16384,0, 0,0, 0,0, 16384,0, 21,22, 23,24, 1, 21,22, 23,24);
    send(1, 16384,0, 0,0, 0,0, 16384,0, -31,32, -33,34, 1, -31,32, -33,34);
    idle(4);

    // Back-to-back stream with fixed random H_inv
    for (int i = 0; i < 8; i++) hr[i] = int'($urandom_range(65535)) - 32768;
    for (int i = 0; i < 64; i++) begin
      send(1, hr[0], hr[1], hr[2], hr[3], hr[4], hr[5], hr[6], hr[7],
           int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768,
           int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768,
           0, 0, 0, 0, 0);
    end
    idle(4);

    // Reset mid-stream: the last two in-flight samples and the in_valid held during rst are dropped
    send(1, 16384,0, 0,0, 0,0, 16384,0, 41,42, 43,44, 1, 41,42, 43,44);
    send(1, 16384,0, 0,0, 0,0, 16384,0, 51,52, 53,54, 1, 51,52, 53,54);
    send(1, 16384,0, 0,0, 0,0, 16384,0, 61,62, 63,64, 1, 61,62, 63,64);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    sb_q.delete();
    @(negedge clk);
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_X1_re", int'(bus.X1_re), 0);
    chk("midrst_X1_im", int'(bus.X1_im), 0);
    chk("midrst_X2_re", int'(bus.X2_re), 0);
    chk("midrst_X2_im", int'(bus.X2_im), 0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    idle(6);

    send(1, 16384,0, 0,0, 0,0, 16384,0, 71,-72, 73,-74, 1, 71,-72, 73,-74);
    bus.in_valid = 1'b0;

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
      @(negedge clk); #1;
    end
    chk("drain_pending", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
